uart_counter_cmd_ctrl: RTL and testbench
========================================

// Module: uart_counter_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART and the 0-9999 counter datapath.
//  Merges debounced button levels and received UART command bytes into the datapath
//  controls: enable (run/stop), mode (up/down) and clear.
//  On a status request, snapshots the count, converts it to ASCII decimal and
//  streams "DDDD\r\n" to the UART transmitter via the tx_start/tx_busy handshake.
// PARAMETERS
//  COUNT_W      14    width of count_in ($clog2(10000))
//  MAX_COUNT    9999  snapshot clamp value
//  ACK_TIMEOUT  1023  cycles to wait for tx_busy=1 after tx_start before aborting
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous reset, active-high
//  rx_data     in   8        received byte, valid when rx_done=1
//  rx_done     in   1        1-cycle pulse: rx_data valid
//  btn_enable  in   1        debounced level, rising edge = run/stop toggle
//  btn_clear   in   1        debounced level, rising edge = clear
//  btn_mode    in   1        debounced level, rising edge = up/down toggle
//  count_in    in   COUNT_W  current datapath count
//  tx_busy     in   1        UART transmitter busy
//  enable      out  1        level to datapath: 1 = run
//  mode        out  1        level to datapath: 0 = up, 1 = down
//  clear       out  1        1-cycle clear pulse to datapath
//  tx_start    out  1        1-cycle pulse: transmit tx_data
//  tx_data     out  8        byte to transmit, held stable until next tx_start
//  cmd_err     out  1        1-cycle pulse: unknown byte, busy reject or tx timeout
// BEHAVIOUR
//  Reset: enable=0, mode=0, clear=0, tx_start=0, tx_data=8'h00, cmd_err=0,
//   FSM=IDLE, button edge registers=0. Reset mid-report aborts with no further bytes.
//  Buttons: registered previous level; event = level & ~prev (one per press).
//  Commands, on rx_done (case-insensitive): 'R'/'r' toggle enable; 'M'/'m' toggle mode;
//   'C'/'c' clear; 'S'/'s' report. Any other byte -> cmd_err pulse.
//  Command effect registered: outputs change on the clock edge after rx_done or
//   button edge detection (1-cycle latency).
//  Button and UART event for the same control in the same cycle count as ONE event
//   (single toggle, single clear pulse). Events on different controls apply together.
//  clear is a 1-cycle pulse; enable and mode are unchanged by clear.
//  R/M/C are processed in every FSM state, including during a report.
//  Report FSM: IDLE -> CONV -> SEND -> WAIT_ACK -> WAIT_DONE -> (SEND | IDLE)
//   IDLE: on 'S', snapshot min(count_in, MAX_COUNT) -> CONV.
//   CONV: 14-cycle shift-add-3 binary-to-BCD, producing 4 digits -> SEND.
//   SEND: when tx_busy=0, drive tx_data = next byte of {d3,d2,d1,d0,8'h0D,8'h0A}
//    (digits as 8'h30+d), pulse tx_start -> WAIT_ACK. Waits in SEND while tx_busy=1.
//   WAIT_ACK: tx_busy=1 -> WAIT_DONE; ACK_TIMEOUT cycles without it -> cmd_err, IDLE.
//   WAIT_DONE: tx_busy=0 -> SEND for the next byte, or IDLE after byte 6 (8'h0A).
//  'S' received while not IDLE: ignored, cmd_err pulse; report in progress unaffected.
//  Snapshot is taken once; count changes during a report do not alter sent digits.
//  Always leading zeros: count 7 sends "0007\r\n".
// TESTING
//  Reset, then rx 'r' -> enable=1 one cycle after rx_done; rx 'R' -> enable=0.
//  btn_mode held high 100 cycles -> mode toggles exactly once; same-cycle btn_mode rise
//   and rx 'm' -> a single toggle.
//  rx 'c' -> clear high exactly 1 cycle; enable and mode unchanged.
//  count_in=1234, rx 's', tx model busy 20 cycles per byte -> bytes 31,32,33,34,0D,0A
//   in order, one tx_start per byte; count_in=12000 -> "9999\r\n".
//  rx 's' during a report -> cmd_err pulse, original 6 bytes intact; rx 'x' -> cmd_err.
//  tx_busy stuck at 0 after tx_start -> cmd_err after ACK_TIMEOUT, FSM IDLE; rst asserted
//   mid-report -> all outputs at reset values, no further tx_start.

Source files
------------

// File: rtl/uart_counter_cmd_ctrl.sv
// Command sequencer between the UART and the 0-9999 counter datapath: merges buttons and
// UART command bytes into run/mode/clear controls and streams "DDDD\r\n" status reports.
module uart_counter_cmd_ctrl #(
    parameter int COUNT_W     = 14,
    parameter int MAX_COUNT   = 9999,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic               btn_enable,
    input  logic               btn_clear,
    input  logic               btn_mode,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               tx_busy,
    output logic               enable,
    output logic               mode,
    output logic               clear,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic               cmd_err
);

    localparam int SH_W  = 16 + COUNT_W;
    localparam int CNT_W = $clog2(COUNT_W + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // One shift-add-3 step: bcd digits live above the binary operand in a single register.
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[COUNT_W + 4*i +: 4] >= 4'd5) begin
                t[COUNT_W + 4*i +: 4] = t[COUNT_W + 4*i +: 4] + 4'd3;
            end else begin
                t[COUNT_W + 4*i +: 4] = t[COUNT_W + 4*i +: 4];
            end
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    function automatic logic [7:0] report_byte(input logic [15:0] bcd, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h30 + {4'h0, bcd[15:12]};
            3'd1:    b = 8'h30 + {4'h0, bcd[11:8]};
            3'd2:    b = 8'h30 + {4'h0, bcd[7:4]};
            3'd3:    b = 8'h30 + {4'h0, bcd[3:0]};
            3'd4:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    state_t             state_q, state_d;
    logic [SH_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               cmd_err_q, cmd_err_d;
    logic               enable_q, enable_d;
    logic               mode_q, mode_d;
    logic               clear_q, clear_d;
    logic               btn_en_prev_q, btn_clr_prev_q, btn_mode_prev_q;

    logic [7:0]         rx_uc_s;
    logic               cmd_r_s, cmd_m_s, cmd_c_s, cmd_s_s, cmd_unk_s;
    logic               fsm_err_s;
    logic [COUNT_W-1:0] snap_s;

    // Command decode; clearing bit 5 folds lower-case letters onto upper case.
    always_comb begin
        rx_uc_s   = rx_data & 8'hDF;
        cmd_r_s   = rx_done && (rx_uc_s == 8'h52);
        cmd_m_s   = rx_done && (rx_uc_s == 8'h4D);
        cmd_c_s   = rx_done && (rx_uc_s == 8'h43);
        cmd_s_s   = rx_done && (rx_uc_s == 8'h53);
        cmd_unk_s = rx_done && !(cmd_r_s || cmd_m_s || cmd_c_s || cmd_s_s);
        snap_s    = (count_in > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : count_in;
    end

    // Control levels: a button edge and a UART command on the same control merge into one event.
    always_comb begin
        enable_d = enable_q ^ (cmd_r_s | (btn_enable & ~btn_en_prev_q));
        mode_d   = mode_q ^ (cmd_m_s | (btn_mode & ~btn_mode_prev_q));
        clear_d  = cmd_c_s | (btn_clear & ~btn_clr_prev_q);
        cmd_err_d = cmd_unk_s | (cmd_s_s && (state_q != ST_IDLE)) | fsm_err_s;
    end

    // Report FSM next-state and transmit outputs.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        conv_cnt_d = conv_cnt_q;
        byte_idx_d = byte_idx_q;
        tmo_d      = tmo_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fsm_err_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_s_s) begin
                    shift_d    = {16'h0000, snap_s};
                    conv_cnt_d = '0;
                    byte_idx_d = 3'd0;
                    state_d    = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                shift_d = dd_step(shift_q);
                if (conv_cnt_q == CNT_W'(COUNT_W - 1)) begin
                    state_d = ST_SEND;
                end else begin
                    conv_cnt_d = conv_cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = report_byte(shift_q[SH_W-1 -: 16], byte_idx_q);
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_WAIT_ACK;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    fsm_err_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (byte_idx_q == 3'd5) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            shift_q         <= '0;
            conv_cnt_q      <= '0;
            byte_idx_q      <= 3'd0;
            tmo_q           <= '0;
            tx_start_q      <= 1'b0;
            tx_data_q       <= 8'h00;
            cmd_err_q       <= 1'b0;
            enable_q        <= 1'b0;
            mode_q          <= 1'b0;
            clear_q         <= 1'b0;
            btn_en_prev_q   <= 1'b0;
            btn_clr_prev_q  <= 1'b0;
            btn_mode_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            conv_cnt_q      <= conv_cnt_d;
            byte_idx_q      <= byte_idx_d;
            tmo_q           <= tmo_d;
            tx_start_q      <= tx_start_d;
            tx_data_q       <= tx_data_d;
            cmd_err_q       <= cmd_err_d;
            enable_q        <= enable_d;
            mode_q          <= mode_d;
            clear_q         <= clear_d;
            btn_en_prev_q   <= btn_enable;
            btn_clr_prev_q  <= btn_clear;
            btn_mode_prev_q <= btn_mode;
        end
    end

    assign enable   = enable_q;
    assign mode     = mode_q;
    assign clear    = clear_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_uart_counter_cmd_ctrl.sv
// Scoreboard bench for uart_counter_cmd_ctrl: expected report bytes are queued by the
// stimulus, a negedge monitor pops and compares them on every tx_start.
module tb_uart_counter_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        btn_enable, btn_clear, btn_mode;
    logic [13:0] count_in;
    logic        tx_busy;
    logic        enable, mode, clear, tx_start, cmd_err;
    logic [7:0]  tx_data;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    int          tx_cnt = 0, err_cnt = 0, clr_cnt = 0, mode_chg = 0;
    logic        mode_prev = 1'b0;
    bit          tx_dead = 1'b0;
    int          e0, t0, c0, m0;

    uart_counter_cmd_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .btn_enable(btn_enable), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .count_in(count_in), .tx_busy(tx_busy), .enable(enable), .mode(mode),
        .clear(clear), .tx_start(tx_start), .tx_data(tx_data), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic push_report(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("report_drained", exp_q.size(), 0);
    endtask

    // Transmitter model: busy for 20 cycles after each tx_start unless it is playing dead.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start && !tx_dead) begin
                tx_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on tx_start, event counting for pulses and mode changes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_start) begin
                    tx_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_byte: unexpected tx_start with data %02h", tx_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (tx_data !== mon_exp) begin
                            errors++;
                            $display("FAIL tx_byte: got %02h expected %02h", tx_data, mon_exp);
                        end
                    end
                end
                if (cmd_err) err_cnt++;
                if (clear) clr_cnt++;
                if (mode !== mode_prev) mode_chg++;
            end
            mode_prev = mode;
        end
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0;
        btn_enable = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0; count_in = 14'd0;
        cycles(3);
        check("rst_enable", enable, 0);
        check("rst_mode", mode, 0);
        check("rst_clear", clear, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        cycles(2);

        check("enable_before_r", enable, 0);
        send_byte(8'h72);
        check("enable_after_r", enable, 1);
        send_byte(8'h52);
        check("enable_after_R", enable, 0);

        m0 = mode_chg;
        btn_mode = 1'b1;
        cycles(100);
        btn_mode = 1'b0;
        cycles(3);
        check("btn_mode_hold_toggles", mode_chg - m0, 1);
        check("btn_mode_value", mode, 1);

        m0 = mode_chg;
        @(negedge clk);
        btn_mode = 1'b1; rx_data = 8'h6D; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        cycles(3);
        btn_mode = 1'b0;
        cycles(2);
        check("merged_mode_toggles", mode_chg - m0, 1);
        check("merged_mode_value", mode, 0);

        send_byte(8'h72);
        c0 = clr_cnt;
        send_byte(8'h63);
        cycles(3);
        check("clear_pulse_cycles", clr_cnt - c0, 1);
        check("clear_keeps_enable", enable, 1);
        check("clear_keeps_mode", mode, 0);

        count_in = 14'd1234;
        push_report(8'h31, 8'h32, 8'h33, 8'h34);
        e0 = err_cnt; t0 = tx_cnt;
        send_byte(8'h73);
        count_in = 14'd5000;
        cycles(30);
        send_byte(8'h53);
        wait_drain(600);
        cycles(30);
        check("busy_s_err", err_cnt - e0, 1);
        check("report_1234_bytes", tx_cnt - t0, 6);

        count_in = 14'd12000;
        push_report(8'h39, 8'h39, 8'h39, 8'h39);
        send_byte(8'h73);
        wait_drain(600);
        cycles(30);

        e0 = err_cnt;
        send_byte(8'h78);
        cycles(3);
        check("unknown_byte_err", err_cnt - e0, 1);

        tx_dead = 1'b1;
        count_in = 14'd7;
        exp_q.push_back(8'h30);
        e0 = err_cnt; t0 = tx_cnt;
        send_byte(8'h73);
        cycles(1100);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_one_start", tx_cnt - t0, 1);
        tx_dead = 1'b0;
        cycles(5);

        push_report(8'h30, 8'h30, 8'h30, 8'h37);
        e0 = err_cnt;
        send_byte(8'h73);
        wait_drain(600);
        cycles(30);
        check("idle_after_timeout", err_cnt - e0, 0);

        send_byte(8'h6D);
        count_in = 14'd42;
        exp_q.push_back(8'h30);
        t0 = tx_cnt;
        send_byte(8'h73);
        begin
            int n;
            n = 0;
            while (tx_cnt == t0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("first_byte_before_reset", tx_cnt - t0, 1);
        cycles(3);
        rst = 1'b1;
        cycles(1);
        check("midrst_enable", enable, 0);
        check("midrst_mode", mode, 0);
        check("midrst_clear", clear, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_cmd_err", cmd_err, 0);
        cycles(1);
        rst = 1'b0;
        cycles(200);
        check("no_tx_after_reset", tx_cnt - t0, 1);
        check("queue_empty_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
